// File: rtl/dpram_port_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter: per-requester request
// fields in, per-requester grant/read-return pulses out.
interface dpram_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port RAM among NREQ requesters;
// issues up to two operations per cycle and routes 1-cycle read data back.
module dpram_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 8
) (
  input  logic                clk,
  input  logic                rst,
  dpram_port_arbiter_if.slave bus,
  output logic                ram_cs,
  output logic                ram_we1,
  output logic                ram_we2,
  output logic                ram_re1,
  output logic                ram_re2,
  output logic                ram_oe1,
  output logic                ram_oe2,
  output logic [AW-1:0]       ram_addr1,
  output logic [AW-1:0]       ram_addr2,
  output logic [DW-1:0]       ram_din1,
  output logic [DW-1:0]       ram_din2,
  input  logic [DW-1:0]       ram_dout1,
  input  logic [DW-1:0]       ram_dout2
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, RESP} pstate_e;

  pstate_e         pst   [2];
  pstate_e         pst_n [2];
  logic [IW-1:0]   pidx  [2];
  logic [IW-1:0]   sel   [2];
  logic [IW-1:0]   rr_ptr, rr_n;
  logic [IW-1:0]   ord   [NREQ];
  logic [AW-1:0]   a     [NREQ];
  logic [DW-1:0]   d     [NREQ];
  logic [1:0]      use_p, we_p;
  logic [NREQ-1:0] gnt_c, rvalid_c;
  logic [DW-1:0]   rdata_c;
  logic            rd_done, blocked;

  function automatic int wrap(input int v);
    return (v >= NREQ) ? v - NREQ : v;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a[g] = bus.req_addr[g*AW +: AW];
    assign d[g] = bus.req_wdata[g*DW +: DW];
  end

  always_comb begin
    for (int k = 0; k < NREQ; k++) ord[k] = IW'(wrap(int'(rr_ptr) + k));
  end

  // Scan in round-robin order; each candidate takes the lowest port that accepts it.
  // A candidate is held back by an earlier requester on the same address (if either
  // writes) and by a read already issued this cycle, since rdata is shared.
  always_comb begin
    gnt_c   = '0;
    use_p   = '0;
    we_p    = '0;
    sel[0]  = '0;
    sel[1]  = '0;
    rd_done = 1'b0;
    blocked = 1'b0;
    rr_n    = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      blocked = !ram_cs || !bus.req[ord[k]] || (rd_done && !bus.req_we[ord[k]]);
      for (int j = 0; j < k; j++)
        if (bus.req[ord[j]] && a[ord[j]] == a[ord[k]] &&
            (bus.req_we[ord[j]] || bus.req_we[ord[k]]))
          blocked = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (!blocked && !use_p[p] && (pst[p] == IDLE || !bus.req_we[ord[k]])) begin
          use_p[p]        = 1'b1;
          we_p[p]         = bus.req_we[ord[k]];
          sel[p]          = ord[k];
          gnt_c[ord[k]]   = 1'b1;
          rd_done         = rd_done | !bus.req_we[ord[k]];
          rr_n            = (int'(ord[k]) == NREQ - 1) ? '0 : ord[k] + 1'b1;
          blocked         = 1'b1;
        end
      end
    end
    for (int p = 0; p < 2; p++) pst_n[p] = (use_p[p] && !we_p[p]) ? RESP : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_cs <= 1'b0;
      rr_ptr <= '0;
      for (int p = 0; p < 2; p++) begin
        pst[p]  <= IDLE;
        pidx[p] <= '0;
      end
    end else begin
      ram_cs <= 1'b1;
      rr_ptr <= rr_n;
      for (int p = 0; p < 2; p++) begin
        pst[p]  <= pst_n[p];
        pidx[p] <= sel[p];
      end
    end
  end

  // At most one port can be in RESP, so the shared rdata never has two sources.
  always_comb begin
    rvalid_c = '0;
    rdata_c  = '0;
    if (pst[0] == RESP) begin
      rvalid_c[pidx[0]] = 1'b1;
      rdata_c           = ram_dout1;
    end
    if (pst[1] == RESP) begin
      rvalid_c[pidx[1]] = 1'b1;
      rdata_c           = ram_dout2;
    end
  end

  assign bus.gnt    = gnt_c;
  assign bus.rvalid = rvalid_c;
  assign bus.rdata  = rdata_c;

  assign ram_we1   = use_p[0] & we_p[0];
  assign ram_we2   = use_p[1] & we_p[1];
  assign ram_re1   = (use_p[0] & ~we_p[0]) | (pst[0] == RESP);
  assign ram_re2   = (use_p[1] & ~we_p[1]) | (pst[1] == RESP);
  assign ram_oe1   = ram_re1;
  assign ram_oe2   = ram_re2;
  assign ram_addr1 = use_p[0] ? a[sel[0]] : '0;
  assign ram_addr2 = use_p[1] ? a[sel[1]] : '0;
  assign ram_din1  = (use_p[0] & we_p[0]) ? d[sel[0]] : '0;
  assign ram_din2  = (use_p[1] & we_p[1]) ? d[sel[1]] : '0;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Scoreboard bench for dpram_port_arbiter: directed scenarios push expected grant
// and read-return events; a forked monitor pops and compares them at negedge.
module tb_dpram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic       ram_cs, ram_we1, ram_we2, ram_re1, ram_re2, ram_oe1, ram_oe2;
  logic [4:0] ram_addr1, ram_addr2;
  logic [7:0] ram_din1, ram_din2, ram_dout1, ram_dout2;

  dpram_port_arbiter_if #(.NREQ(4), .AW(5), .DW(8)) bus ();

  dpram_port_arbiter #(.NREQ(4), .AW(5), .DW(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_cs(ram_cs), .ram_we1(ram_we1), .ram_we2(ram_we2),
    .ram_re1(ram_re1), .ram_re2(ram_re2), .ram_oe1(ram_oe1), .ram_oe2(ram_oe2),
    .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
    .ram_din1(ram_din1), .ram_din2(ram_din2),
    .ram_dout1(ram_dout1), .ram_dout2(ram_dout2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 32x8 dual-port RAM with registered reads
  logic [7:0] mem [32] = '{default: 8'h00};
  logic [7:0] q1, q2;
  always @(posedge clk) begin
    if (ram_cs && ram_we1) mem[ram_addr1] <= ram_din1;
    if (ram_cs && ram_we2) mem[ram_addr2] <= ram_din2;
    if (ram_cs && ram_re1) q1 <= mem[ram_addr1];
    if (ram_cs && ram_re2) q2 <= mem[ram_addr2];
  end
  assign ram_dout1 = ram_oe1 ? q1 : 8'h00;
  assign ram_dout2 = ram_oe2 ? q2 : 8'h00;

  typedef struct {
    int         cyc;
    logic [3:0] m;
    logic [4:0] a1, a2;
    logic       w1, w2;
  } gexp_t;
  typedef struct {
    int         cyc;
    logic [3:0] m;
    logic [7:0] d;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t ge;
  rexp_t re;
  int    c0, c1;
  logic [4:0] t3a [4] = '{5'h05, 5'h03, 5'h1F, 5'h00};
  logic [7:0] t3d [4] = '{8'hA5, 8'h11, 8'h22, 8'h00};

  function automatic void eg(input int c, input logic [3:0] m, input logic [4:0] a1,
                             input logic w1, input logic [4:0] a2, input logic w2);
    gexp_t e;
    e.cyc = c; e.m = m; e.a1 = a1; e.w1 = w1; e.a2 = a2; e.w2 = w2;
    gq.push_back(e);
  endfunction

  function automatic void er(input int c, input logic [3:0] m, input logic [7:0] dd);
    rexp_t e;
    e.cyc = c; e.m = m; e.d = dd;
    rq.push_back(e);
  endfunction

  function automatic bit outs_zero();
    return {bus.gnt, bus.rvalid, bus.rdata, ram_we1, ram_we2, ram_re1, ram_re2,
            ram_oe1, ram_oe2, ram_addr1, ram_addr2, ram_din1, ram_din2} == '0;
  endfunction

  task automatic set_req(input int i, input logic we, input logic [4:0] a,
                         input logic [7:0] dd);
    bus.req_we[i]          = we;
    bus.req_addr[i*5 +: 5] = a;
    bus.req_wdata[i*8 +: 8] = dd;
    bus.req[i]             = 1'b1;
  endtask

  // one cycle of requester behaviour: drop each request once it has been granted
  task automatic tick();
    logic [3:0] g;
    @(negedge clk);
    g = bus.gnt;
    @(posedge clk);
    #1;
    bus.req = bus.req & ~g;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((bus.req != 0 || gq.size() != 0 || rq.size() != 0) && n < 30) begin
      tick();
      n++;
    end
    total++;
    if (n >= 30 || gq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL %s drain: req=%b gq=%0d rq=%0d left, need all 0", name, bus.req,
               gq.size(), rq.size());
      gq.delete();
      rq.delete();
    end
  endtask

  task automatic do_reset();
    bus.req = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (!outs_zero() || ram_cs !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs: cs=%b gnt=%b rvalid=%b re1=%b, need all 0", ram_cs,
               bus.gnt, bus.rvalid, ram_re1);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (!outs_zero() || ram_cs !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: cs=%b gnt=%b rvalid=%b, need cs=1 rest 0", ram_cs,
               bus.gnt, bus.rvalid);
    end
  endtask

  initial begin
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (bus.gnt != 0) begin
            total++;
            if (gq.size() == 0) begin
              bad++;
              $display("FAIL gnt_unexpected: cyc=%0d gnt=%b, need none", cyc, bus.gnt);
            end else begin
              ge = gq.pop_front();
              if (cyc != ge.cyc || bus.gnt != ge.m || ram_addr1 != ge.a1 || ram_we1 != ge.w1 ||
                  ram_addr2 != ge.a2 || ram_we2 != ge.w2) begin
                bad++;
                $display("FAIL gnt: got cyc=%0d m=%b a1=%h w1=%b a2=%h w2=%b need cyc=%0d m=%b a1=%h w1=%b a2=%h w2=%b",
                         cyc, bus.gnt, ram_addr1, ram_we1, ram_addr2, ram_we2,
                         ge.cyc, ge.m, ge.a1, ge.w1, ge.a2, ge.w2);
              end
            end
          end
          if (bus.rvalid != 0) begin
            total++;
            if (rq.size() == 0) begin
              bad++;
              $display("FAIL rvalid_unexpected: cyc=%0d rvalid=%b rdata=%h, need none", cyc,
                       bus.rvalid, bus.rdata);
            end else begin
              re = rq.pop_front();
              if (cyc != re.cyc || bus.rvalid != re.m || bus.rdata != re.d) begin
                bad++;
                $display("FAIL rvalid: got cyc=%0d m=%b d=%h need cyc=%0d m=%b d=%h",
                         cyc, bus.rvalid, bus.rdata, re.cyc, re.m, re.d);
              end
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
    join_none

    // reset and idle
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (!outs_zero() || ram_cs !== 1'b1) begin
      bad++;
      $display("FAIL idle: cs=%b gnt=%b re1=%b, need cs=1 rest 0", ram_cs, bus.gnt, ram_re1);
    end

    // write then read of same address: hazard serialises them
    do_reset();
    c0 = cyc;
    set_req(0, 1'b1, 5'h05, 8'hA5);
    set_req(1, 1'b0, 5'h05, 8'h00);
    eg(c0,     4'b0001, 5'h05, 1'b1, 5'h00, 1'b0);
    eg(c0 + 1, 4'b0010, 5'h05, 1'b0, 5'h00, 1'b0);
    er(c0 + 2, 4'b0010, 8'hA5);
    drain("raw_same_addr");

    // two writes on both ports, then read-back one read per cycle
    do_reset();
    c0 = cyc;
    set_req(0, 1'b1, 5'h03, 8'h11);
    set_req(2, 1'b1, 5'h1F, 8'h22);
    eg(c0, 4'b0101, 5'h03, 1'b1, 5'h1F, 1'b1);
    tick();
    set_req(0, 1'b0, 5'h03, 8'h00);
    set_req(2, 1'b0, 5'h1F, 8'h00);
    eg(c0 + 1, 4'b0001, 5'h03, 1'b0, 5'h00, 1'b0);
    eg(c0 + 2, 4'b0100, 5'h1F, 1'b0, 5'h00, 1'b0);
    er(c0 + 2, 4'b0001, 8'h11);
    er(c0 + 3, 4'b0100, 8'h22);
    drain("dual_write_readback");

    // all four requesters hold reads: round robin, back-to-back returns
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, t3a[i], 8'h00);
    for (int n = 0; n < 5; n++) begin
      eg(c0 + n, 4'(1 << (n % 4)), t3a[n % 4], 1'b0, 5'h00, 1'b0);
      er(c0 + n + 1, 4'(1 << (n % 4)), t3d[n % 4]);
    end
    for (int n = 0; n < 5; n++) begin
      tick();
      if (n < 4) bus.req = 4'hF;
      else bus.req = 4'h0;
    end
    drain("rr_reads");

    // two writes to the same address serialise in scan order
    do_reset();
    c0 = cyc;
    set_req(1, 1'b1, 5'h0A, 8'h77);
    set_req(3, 1'b1, 5'h0A, 8'h88);
    eg(c0,     4'b0010, 5'h0A, 1'b1, 5'h00, 1'b0);
    eg(c0 + 1, 4'b1000, 5'h0A, 1'b1, 5'h00, 1'b0);
    tick();
    tick();
    set_req(0, 1'b0, 5'h0A, 8'h00);
    eg(c0 + 2, 4'b0001, 5'h0A, 1'b0, 5'h00, 1'b0);
    er(c0 + 3, 4'b0001, 8'h88);
    drain("waw_same_addr");

    // reset during the return cycle of a read
    do_reset();
    c0 = cyc;
    set_req(2, 1'b0, 5'h05, 8'h00);
    eg(c0, 4'b0100, 5'h05, 1'b0, 5'h00, 1'b0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (!outs_zero() || ram_cs !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_read: cs=%b rvalid=%b rdata=%h re1=%b, need all 0", ram_cs,
               bus.rvalid, bus.rdata, ram_re1);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    c1 = cyc;
    set_req(1, 1'b0, 5'h03, 8'h00);
    set_req(3, 1'b0, 5'h1F, 8'h00);
    eg(c1,     4'b0010, 5'h03, 1'b0, 5'h00, 1'b0);
    eg(c1 + 1, 4'b1000, 5'h1F, 1'b0, 5'h00, 1'b0);
    er(c1 + 1, 4'b0010, 8'h11);
    er(c1 + 2, 4'b1000, 8'h22);
    drain("after_mid_reset");
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
